// File: rtl/fccc_lock_seq.sv
// Lock qualifier and staggered reset sequencer behind an FCCC: debounces LOCK,
// releases per-domain resets in order, drives per-domain clock enables and tracks lock loss.
module fccc_lock_seq #(
  parameter int NUM_CH             = 4,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SEQ_GAP            = 8,
  parameter int DIV_W              = 8,
  parameter int CNT_W              = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LOCK,
  input  logic                    FORCE_RST,
  input  logic                    CLR_STATUS,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic [NUM_CH-1:0]       RST_OUT,
  output logic [NUM_CH-1:0]       CE_OUT,
  output logic                    READY,
  output logic                    LOCK_LOST,
  output logic [CNT_W-1:0]        LOCK_LOSS_CNT,
  output logic [1:0]              STATE
);

  localparam int ST_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GAP_W = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SEQ_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    SEQ       = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               lock_m, lock_s, force_s;
  logic [ST_W-1:0]    stable_cnt, stable_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [IDX_W-1:0]   ch_idx, idx_nxt;
  logic [NUM_CH-1:0]  rst_nxt;
  logic               ready_nxt, lost_nxt, loss;
  logic [CNT_W-1:0]   cnt_base, cnt_nxt;
  logic [DIV_W-1:0]   div_cnt [NUM_CH];

  assign STATE = state;

  // Input stage: LOCK crosses into CLK through two flops; FORCE_RST is registered once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_m  <= 1'b0;
      lock_s  <= 1'b0;
      force_s <= 1'b0;
    end else begin
      lock_m  <= LOCK;
      lock_s  <= lock_m;
      force_s <= FORCE_RST;
    end
  end

  always_comb begin
    state_nxt  = state;
    stable_nxt = stable_cnt;
    gap_nxt    = gap_cnt;
    idx_nxt    = ch_idx;
    rst_nxt    = RST_OUT;
    ready_nxt  = READY;
    loss       = (state != WAIT_LOCK) && !lock_s;

    case (state)
      WAIT_LOCK: begin
        rst_nxt = '1;
        if (lock_s && !force_s) begin
          state_nxt  = STABLE;
          stable_nxt = '0;
        end
      end
      STABLE: begin
        if (stable_cnt == ST_LAST) begin
          rst_nxt[0] = 1'b0;
          gap_nxt    = '0;
          idx_nxt    = IDX_W'(1);
          if (NUM_CH == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = SEQ;
          end
        end else begin
          stable_nxt = stable_cnt + 1'b1;
        end
      end
      SEQ: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt         = '0;
          rst_nxt[ch_idx] = 1'b0;
          idx_nxt         = ch_idx + 1'b1;
          if (ch_idx == IDX_LAST) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      RUN: ;
      default: state_nxt = WAIT_LOCK;
    endcase

    // Lock loss and software reset both collapse every domain back into reset
    if (loss || force_s) begin
      state_nxt  = WAIT_LOCK;
      rst_nxt    = '1;
      ready_nxt  = 1'b0;
      stable_nxt = '0;
      gap_nxt    = '0;
    end

    // Clear is applied first so a coincident loss event still lands as count 1
    cnt_base = CLR_STATUS ? '0 : LOCK_LOSS_CNT;
    lost_nxt = CLR_STATUS ? 1'b0 : LOCK_LOST;
    cnt_nxt  = cnt_base;
    if (loss) begin
      lost_nxt = 1'b1;
      if (cnt_base != '1) cnt_nxt = cnt_base + 1'b1;
    end
  end

  // Sequencer state and status registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= WAIT_LOCK;
      stable_cnt    <= '0;
      gap_cnt       <= '0;
      ch_idx        <= '0;
      RST_OUT       <= '1;
      READY         <= 1'b0;
      LOCK_LOST     <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      state         <= state_nxt;
      stable_cnt    <= stable_nxt;
      gap_cnt       <= gap_nxt;
      ch_idx        <= idx_nxt;
      RST_OUT       <= rst_nxt;
      READY         <= ready_nxt;
      LOCK_LOST     <= lost_nxt;
      LOCK_LOSS_CNT <= cnt_nxt;
    end
  end

  // Clock-enable dividers run off the next reset value so DIV=0 enables on the release edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CE_OUT <= '0;
      for (int k = 0; k < NUM_CH; k++) div_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rst_nxt[k]) begin
          div_cnt[k] <= '0;
          CE_OUT[k]  <= 1'b0;
        end else if (div_cnt[k] >= DIV[k*DIV_W +: DIV_W]) begin
          div_cnt[k] <= '0;
          CE_OUT[k]  <= 1'b1;
        end else begin
          div_cnt[k] <= div_cnt[k] + 1'b1;
          CE_OUT[k]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fccc_lock_seq.sv
// Directed bench for fccc_lock_seq: release times and clock-enable pulses are queued
// as expectations when stimulus is applied and compared as the outputs appear.
module tb_fccc_lock_seq;
  localparam int NUM_CH = 4;
  localparam int LSC    = 16;
  localparam int GAP    = 8;
  localparam int DIV_W  = 8;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset, lock, force_rst, clr_status;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       rst_out, ce_out;
  logic                    ready, lock_lost;
  logic [CNT_W-1:0]        loss_cnt;
  logic [1:0]              state;

  fccc_lock_seq #(
    .NUM_CH(NUM_CH), .LOCK_STABLE_CYCLES(LSC), .SEQ_GAP(GAP), .DIV_W(DIV_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RESET(reset), .LOCK(lock), .FORCE_RST(force_rst), .CLR_STATUS(clr_status),
    .DIV(div), .RST_OUT(rst_out), .CE_OUT(ce_out), .READY(ready), .LOCK_LOST(lock_lost),
    .LOCK_LOSS_CNT(loss_cnt), .STATE(state)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int at;} fall_t;

  int                errors = 0;
  int                checks = 0;
  int                cyc    = 0;
  int                exp_cnt;
  int                d [NUM_CH];
  fall_t             fall_q[$];
  logic [NUM_CH-1:0] ce_q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_div();
    for (int k = 0; k < NUM_CH; k++) div[k*DIV_W +: DIV_W] = DIV_W'(d[k]);
  endtask

  task automatic push_seq(input int e0);
    for (int k = 0; k < NUM_CH; k++) fall_q.push_back('{ch: k, at: e0 + LSC + 2 + k*GAP});
  endtask

  // Steps n edges, matching each released channel against the head of the release queue
  task automatic watch(input int n, input bit use_ce);
    logic [NUM_CH-1:0] prev;
    logic [NUM_CH-1:0] e;
    fall_t             f;
    prev = rst_out;
    repeat (n) begin
      step();
      for (int k = 0; k < NUM_CH; k++) begin
        if (prev[k] && !rst_out[k]) begin
          if (fall_q.size() == 0) begin
            chk("unexpected_release", 32'(k), 32'hFFFF);
          end else begin
            f = fall_q.pop_front();
            chk("release_ch", 32'(k), 32'(f.ch));
            chk("release_edge", 32'(cyc), 32'(f.at));
            chk("ready_at_release", 32'(ready), 32'(k == NUM_CH - 1));
          end
        end
      end
      if (use_ce && ce_q.size() > 0) begin
        e = ce_q.pop_front();
        chk("ce_out", 32'(ce_out), 32'(e));
      end
      prev = rst_out;
    end
    chk("releases_pending", 32'(fall_q.size()), 32'd0);
    fall_q.delete();
    ce_q.delete();
  endtask

  task automatic lock_up();
    int n;
    lock = 1'b1;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk("lock_up_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, p, r;
    logic [NUM_CH-1:0] v;
    reset = 1'b1; lock = 1'b0; force_rst = 1'b0; clr_status = 1'b0;
    d = '{0, 1, 3, 255};
    set_div();
    repeat (3) step();
    chk("rst_rst_out", 32'(rst_out), 32'hF);
    chk("rst_ce_out", 32'(ce_out), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_loss_cnt", 32'(loss_cnt), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    step();

    // Power-up with dividers {0,1,3,255}
    lock = 1'b1;
    e0 = cyc + 1;
    push_seq(e0);
    for (int t = cyc + 1; t <= cyc + 600; t++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r = e0 + LSC + 2 + k*GAP + d[k];
        v[k] = (t >= r) && (((t - r) % (d[k] + 1)) == 0);
      end
      ce_q.push_back(v);
    end
    watch(600, 1'b1);
    chk("pwr_ready", 32'(ready), 32'd1);
    chk("pwr_state", 32'(state), 32'd3);

    // DIV[2] raised to 200 right after a pulse, then lowered to 5 at count 100
    p = 0;
    step();
    while (!ce_out[2] && p < 10) begin
      step();
      p++;
    end
    chk("ce2_found", 32'(ce_out[2]), 32'd1);
    d[2] = 200;
    set_div();
    for (int i = 1; i <= 120; i++) begin
      step();
      chk("ce2_div_change", 32'(ce_out[2]), 32'((i == 101) || (i > 101 && ((i - 101) % 6) == 0)));
      if (i == 100) begin
        d[2] = 5;
        set_div();
      end
    end

    // Loss in RUN
    lock = 1'b0;
    step();
    chk("loss_f0_rst", 32'(rst_out), 32'd0);
    step();
    chk("loss_f1_rst", 32'(rst_out), 32'd0);
    step();
    chk("loss_f2_rst", 32'(rst_out), 32'hF);
    chk("loss_f2_ce", 32'(ce_out), 32'd0);
    chk("loss_f2_ready", 32'(ready), 32'd0);
    chk("loss_f2_lost", 32'(lock_lost), 32'd1);
    chk("loss_f2_state", 32'(state), 32'd0);
    chk("loss_f2_cnt", 32'(loss_cnt), 32'd1);

    // Reset clears the sticky status
    reset = 1'b1;
    step();
    chk("mid_rst_lost", 32'(lock_lost), 32'd0);
    chk("mid_rst_cnt", 32'(loss_cnt), 32'd0);
    chk("mid_rst_rst_out", 32'(rst_out), 32'hF);
    chk("mid_rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    step();

    // Debounce restart: 3-cycle drop after 10 STABLE cycles
    lock = 1'b1;
    e0 = cyc + 1;
    repeat (12) step();
    chk("deb_stable", 32'(state), 32'd1);
    lock = 1'b0;
    repeat (3) step();
    chk("deb_state", 32'(state), 32'd0);
    chk("deb_cnt", 32'(loss_cnt), 32'd1);
    lock = 1'b1;
    push_seq(cyc + 1);
    watch(45, 1'b0);
    exp_cnt = 1;

    // FORCE_RST single-cycle pulse in RUN
    force_rst = 1'b1;
    step();
    e0 = cyc;
    chk("force_g0_rst", 32'(rst_out), 32'd0);
    force_rst = 1'b0;
    step();
    chk("force_g1_rst", 32'(rst_out), 32'hF);
    chk("force_g1_state", 32'(state), 32'd0);
    chk("force_cnt", 32'(loss_cnt), 32'(exp_cnt));
    chk("force_lost", 32'(lock_lost), 32'd1);
    push_seq(e0);
    watch(45, 1'b0);
    chk("force_rerun_state", 32'(state), 32'd3);

    // FORCE_RST held for 50 cycles
    force_rst = 1'b1;
    step();
    for (int i = 0; i < 50; i++) begin
      step();
      chk("force_hold_state", 32'(state), 32'd0);
    end
    force_rst = 1'b0;
    push_seq(cyc);
    watch(45, 1'b0);
    chk("force_hold_cnt", 32'(loss_cnt), 32'(exp_cnt));

    // Repeated loss until the counter saturates
    for (int i = 0; i < 300; i++) begin
      lock_up();
      lock = 1'b0;
      repeat (3) step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("sat_cnt", 32'(loss_cnt), 32'(exp_cnt));
    end
    chk("sat_final", 32'(loss_cnt), 32'd255);

    // CLR_STATUS coincident with a loss event
    lock_up();
    lock = 1'b0;
    step();
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_loss_cnt", 32'(loss_cnt), 32'd1);
    chk("clr_loss_lost", 32'(lock_lost), 32'd1);

    // CLR_STATUS alone
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_cnt", 32'(loss_cnt), 32'd0);
    chk("clr_lost", 32'(lock_lost), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fccc_lock_seq.md
# fccc_lock_seq

Parametrised lock qualifier and reset sequencer placed directly downstream of an FCCC instance, clocked by the CCC global output. It synchronises and debounces the CCC LOCK signal, then releases NUM_CH per-domain resets in a fixed staggered order. It also generates one programmable clock-enable per domain, and records lock-loss events for firmware. It extends the single GL/LOCK pass-through model with multi-channel sequencing, loss recovery and status reporting.

## Interface
Parameters:
- NUM_CH, 4, number of reset/clock-enable channels (1..16)
- LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronised lock required before release (>=1)
- SEQ_GAP, 8, cycles between successive channel releases (>=1)
- DIV_W, 8, width of each per-channel divide value
- CNT_W, 8, width of the lock-loss event counter

Ports:
- CLK  in  1  fabric clock, CCC global output
- RESET  in  1  synchronous, active-high reset
- LOCK  in  1  CCC lock, asynchronous to CLK
- FORCE_RST  in  1  synchronous software reset request
- CLR_STATUS  in  1  single-cycle pulse; clears LOCK_LOSS_CNT and LOCK_LOST
- DIV  in  NUM_CH*DIV_W  divide value per channel; channel k occupies bits [k*DIV_W +: DIV_W]
- RST_OUT  out  NUM_CH  per-channel reset, active-high
- CE_OUT  out  NUM_CH  per-channel clock-enable pulse
- READY  out  1  high when all channels are released
- LOCK_LOST  out  1  sticky lock-loss flag
- LOCK_LOSS_CNT  out  CNT_W  saturating count of lock-loss events
- STATE  out  2  FSM state: 0 WAIT_LOCK, 1 STABLE, 2 SEQ, 3 RUN

## Operation
- LOCK passes through a 2-FF synchroniser; the second stage is lock_s. Both stages reset to 0.
- Values while RESET is high: RST_OUT all 1, CE_OUT 0, READY 0, LOCK_LOST 0, LOCK_LOSS_CNT 0, STATE WAIT_LOCK.
- RESET asserted mid-operation returns everything to these values at the next edge.
- WAIT_LOCK:
  - All RST_OUT are 1.
  - If lock_s=1 and FORCE_RST=0, go to STABLE with the stable counter at 0.
- STABLE:
  - The counter increments each cycle.
  - When the counter equals LOCK_STABLE_CYCLES-1, go to SEQ. RST_OUT[0] clears on that edge and the gap counter resets to 0.
- SEQ:
  - RST_OUT[k] clears SEQ_GAP*k cycles after RST_OUT[0] clears.
  - On the edge that clears RST_OUT[NUM_CH-1], go to RUN and set READY=1.
  - With NUM_CH=1, the FSM goes from STABLE straight to RUN, and READY rises with RST_OUT[0].
- Lock loss is lock_s=0 in STABLE, SEQ or RUN. At the next edge:
  - all RST_OUT go to 1, CE_OUT to 0 and READY to 0;
  - STATE goes to WAIT_LOCK;
  - LOCK_LOST is set to 1;
  - LOCK_LOSS_CNT increments, saturating at all-ones.
- FORCE_RST=1 in any state has the same effect as lock loss, except that LOCK_LOST and LOCK_LOSS_CNT are unchanged. The FSM stays in WAIT_LOCK while FORCE_RST is held.
- If lock loss and FORCE_RST occur in the same cycle, lock loss is counted.
- If CLR_STATUS coincides with a loss event, the increment wins: the counter becomes 1 and LOCK_LOST becomes 1.
- Divider, per channel k:
  - The counter is held at 0 while RST_OUT[k]=1.
  - Once released, CE_OUT[k] is high for one cycle every DIV[k]+1 cycles. The first pulse falls in the (DIV[k]+1)-th cycle after RST_OUT[k] clears.
  - DIV[k]=0 gives CE_OUT[k] constantly high after release.
  - DIV is sampled live. The wrap condition is counter >= DIV[k], so lowering DIV mid-count wraps on the next cycle with no missed-wrap lockup.
- All outputs are registered.

## Timing
- Let e0 be the first edge at which LOCK is sampled high, with the FSM in WAIT_LOCK.
  - lock_s rises at e1.
  - STABLE is entered at e2.
  - RST_OUT[0] falls at e(LOCK_STABLE_CYCLES+2).
- RST_OUT[k] falls at e(LOCK_STABLE_CYCLES+2+k*SEQ_GAP). READY rises together with RST_OUT[NUM_CH-1].
- Loss detection: LOCK sampled low at edge f0 leads to all RST_OUT high at f2. A LOCK low pulse shorter than one CLK period may be missed.
- FORCE_RST sampled high at edge g0 leads to all RST_OUT high at g0+1.
- A LOCK drop during STABLE restarts debounce from 0 once lock returns; partial counts are never kept.
- The stable and gap counters must be sized for LOCK_STABLE_CYCLES and SEQ_GAP without overflow.

## Test plan
- **Power-up:** NUM_CH=4, LOCK_STABLE_CYCLES=16, SEQ_GAP=8; release RESET, then raise LOCK at e0 -> RST_OUT[0..3] fall at e18/e26/e34/e42, READY=1 at e42, STATE=3.
- **Debounce restart:** LOCK drops for 3 cycles after 10 STABLE cycles, then returns -> STATE returns to 0, LOCK_LOSS_CNT=1, and RST_OUT[0] falls 18 edges after LOCK is sampled high again.
- **Loss in RUN:** LOCK falls -> all RST_OUT=1, CE_OUT=0 and READY=0 two edges later, LOCK_LOST=1. Repeat 300 times with CNT_W=8 -> count saturates at 255.
- **FORCE_RST:** pulse FORCE_RST for 1 cycle in RUN -> resets reassert the next edge, counter unchanged, full sequence reruns. Hold FORCE_RST for 50 cycles -> STATE stays 0.
- **Dividers:** DIV channels = {0,1,3,255} -> CE periods 1/2/4/256 cycles, each first pulse at the correct offset after its release. Change DIV[2] from 200 to 5 while its counter is at 100 -> wrap on the next cycle, then period 6.
- **CLR_STATUS:** CLR_STATUS coincident with a loss event -> LOCK_LOSS_CNT=1, LOCK_LOST=1. CLR_STATUS alone -> both cleared.
